// File: rtl/dcache_wb_mem.sv
// Direct-mapped write-back, write-allocate data cache for the memory stage.
// Optional hit/miss/write-back counters are built when DCACHE_STATS_EN is defined.
module dcache_wb_mem #(
    parameter int unsigned INDEX_BITS     = 3,
    parameter int unsigned LINE_ADDR_BITS = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic [31:0]               rdata,
    output logic                      stall,
    output logic [LINE_ADDR_BITS-1:0] mem_addr,
    output logic [63:0]               mem_wdata,
    output logic                      mem_we,
    input  logic [63:0]               mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt,
    output logic [31:0]               wb_cnt
`endif
);

    localparam int unsigned TagBits = LINE_ADDR_BITS - INDEX_BITS;
    localparam int unsigned Lines   = 2 ** INDEX_BITS;
    localparam int unsigned HiBit   = 3 + LINE_ADDR_BITS;

    typedef enum logic [1:0] {StIdle, StWb, StRefill} cacheStateT;

    cacheStateT stateQ;

    logic               validQ [Lines];
    logic               dirtyQ [Lines];
    logic [TagBits-1:0] tagQ   [Lines];
    logic [63:0]        dataQ  [Lines];

    // Miss address is latched so the sequence completes even if the request drops.
    logic [INDEX_BITS-1:0]     missIndexQ;
    logic [TagBits-1:0]        missTagQ;
    logic                      memWeQ;
    logic [LINE_ADDR_BITS-1:0] memAddrQ;
    logic [63:0]               memWdataQ;

    logic [INDEX_BITS-1:0] reqIndex;
    logic [TagBits-1:0]    reqTag;
    logic                  hit;
    logic                  idleHit;
    logic                  idleMiss;
    logic                  unusedAddrBits;

    assign reqIndex       = req_addr[3 +: INDEX_BITS];
    assign reqTag         = req_addr[3 + INDEX_BITS +: TagBits];
    assign unusedAddrBits = ^{req_addr[31:HiBit], req_addr[1:0]};

    assign hit      = validQ[reqIndex] && (tagQ[reqIndex] == reqTag);
    assign idleHit  = (stateQ == StIdle) && req_valid && hit;
    assign idleMiss = (stateQ == StIdle) && req_valid && !hit;

    always_comb begin
        rdata = 32'd0;
        if (!rst && idleHit && !req_we) begin
            rdata = req_addr[2] ? dataQ[reqIndex][63:32] : dataQ[reqIndex][31:0];
        end
    end

    assign stall     = !rst && ((stateQ != StIdle) || idleMiss);
    assign mem_we    = memWeQ && !rst;
    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;

`ifdef DCACHE_STATS_EN
    logic        replayQ;
    logic [31:0] hitCntQ;
    logic [31:0] missCntQ;
    logic [31:0] wbCntQ;

    assign hit_cnt  = hitCntQ;
    assign miss_cnt = missCntQ;
    assign wb_cnt   = wbCntQ;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StIdle;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            for (int i = 0; i < Lines; i++) begin
                validQ[i] <= 1'b0;
                dirtyQ[i] <= 1'b0;
            end
`ifdef DCACHE_STATS_EN
            replayQ  <= 1'b0;
            hitCntQ  <= '0;
            missCntQ <= '0;
            wbCntQ   <= '0;
`endif
        end else begin
            unique case (stateQ)
                StIdle: begin
`ifdef DCACHE_STATS_EN
                    replayQ <= 1'b0;
                    if (idleHit && !replayQ) hitCntQ <= hitCntQ + 32'd1;
                    if (idleMiss) missCntQ <= missCntQ + 32'd1;
`endif
                    if (idleHit && req_we) begin
                        if (req_addr[2]) dataQ[reqIndex][63:32] <= req_wdata;
                        else             dataQ[reqIndex][31:0]  <= req_wdata;
                        dirtyQ[reqIndex] <= 1'b1;
                    end else if (idleMiss) begin
                        missIndexQ <= reqIndex;
                        missTagQ   <= reqTag;
                        if (validQ[reqIndex] && dirtyQ[reqIndex]) begin
                            stateQ    <= StWb;
                            memWeQ    <= 1'b1;
                            memAddrQ  <= {tagQ[reqIndex], reqIndex};
                            memWdataQ <= dataQ[reqIndex];
`ifdef DCACHE_STATS_EN
                            wbCntQ <= wbCntQ + 32'd1;
`endif
                        end else begin
                            stateQ   <= StRefill;
                            memAddrQ <= {reqTag, reqIndex};
                        end
                    end
                end
                StWb: begin
                    stateQ   <= StRefill;
                    memWeQ   <= 1'b0;
                    memAddrQ <= {missTagQ, missIndexQ};
                end
                StRefill: begin
                    dataQ[missIndexQ]  <= mem_rdata;
                    tagQ[missIndexQ]   <= missTagQ;
                    validQ[missIndexQ] <= 1'b1;
                    dirtyQ[missIndexQ] <= 1'b0;
                    stateQ             <= StIdle;
                    memAddrQ           <= '0;
`ifdef DCACHE_STATS_EN
                    replayQ <= 1'b1;
`endif
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wb_mem.sv
// Bench for dcache_wb_mem: line-level cache/memory model drives per-cycle expectations.
module tb_dcache_wb_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall;
    logic [5:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic [63:0] mem_rdata;

    dcache_wb_mem dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing store seen by the DUT
    logic [63:0] memArr [64];
    assign mem_rdata = memArr[mem_addr];
    always @(posedge clk) if (mem_we) memArr[mem_addr] <= mem_wdata;

    // Reference model: cache lines plus the memory contents the bench expects
    bit          mV    [8];
    bit          mD    [8];
    logic [2:0]  mT    [8];
    logic [63:0] mData [8];
    logic [63:0] refMem [64];

    int tests = 0;
    int fails = 0;

    bit          chk = 1'b0;
    bit          chkAddr;
    logic        expStall;
    logic        expWe;
    logic [31:0] expRdata;
    logic [5:0]  expAddr;
    logic [63:0] expWdata;
    string       phase;
    logic [31:0] sRdata;
    int          stallSeen;

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            check({phase, " stall"}, {63'd0, stall}, {63'd0, expStall});
            check({phase, " rdata"}, {32'd0, rdata}, {32'd0, expRdata});
            check({phase, " mem_we"}, {63'd0, mem_we}, {63'd0, expWe});
            if (chkAddr) check({phase, " mem_addr"}, {58'd0, mem_addr}, {58'd0, expAddr});
            if (expWe) check({phase, " mem_wdata"}, mem_wdata, expWdata);
            sRdata = rdata;
            if (stall) stallSeen++;
        end
    end

    task automatic expectCycle(input logic s, input logic [31:0] r, input logic we, input bit ca,
                               input logic [5:0] a, input logic [63:0] wd, input string ph);
        chk = 1'b1; expStall = s; expRdata = r; expWe = we; chkAddr = ca;
        expAddr = a; expWdata = wd; phase = ph;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 8; i++) begin
            mV[i] = 1'b0;
            mD[i] = 1'b0;
        end
    endtask

    task automatic idleCycle();
        req_valid = 1'b0;
        expectCycle(1'b0, 32'd0, 1'b0, 1'b1, 6'd0, 64'd0, "idle");
        step();
    endtask

    task automatic resetCycle();
        rst = 1'b1;
        req_valid = 1'b0;
        expectCycle(1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 64'd0, "reset");
        step();
        rst = 1'b0;
        clearModel();
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input bit drop, input bit rstRefill,
                          output int stalls, output logic [31:0] rd);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic [5:0]  la;
        logic [5:0]  victim;
        logic [31:0] word;
        idx = addr[5:3];
        tg  = addr[8:6];
        la  = addr[8:3];
        stallSeen = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        if (!(mV[idx] && mT[idx] == tg)) begin
            expectCycle(1'b1, 32'd0, 1'b0, 1'b1, 6'd0, 64'd0, "miss");
            step();
            if (drop) req_valid = 1'b0;
            if (mV[idx] && mD[idx]) begin
                victim = {mT[idx], idx};
                expectCycle(1'b1, 32'd0, 1'b1, 1'b1, victim, mData[idx], "wb");
                step();
                refMem[victim] = mData[idx];
            end
            if (rstRefill) begin
                rst = 1'b1;
                expectCycle(1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 64'd0, "rst-refill");
                step();
                rst = 1'b0;
                req_valid = 1'b0;
                clearModel();
                stalls = stallSeen;
                rd = 32'd0;
                return;
            end
            expectCycle(1'b1, 32'd0, 1'b0, 1'b1, la, 64'd0, "refill");
            step();
            mV[idx] = 1'b1; mD[idx] = 1'b0; mT[idx] = tg; mData[idx] = refMem[la];
        end
        if (req_valid) begin
            word = addr[2] ? mData[idx][63:32] : mData[idx][31:0];
            expectCycle(1'b0, we ? 32'd0 : word, 1'b0, 1'b1, 6'd0, 64'd0, we ? "store" : "load");
            step();
            if (we) begin
                if (addr[2]) mData[idx][63:32] = wd;
                else         mData[idx][31:0]  = wd;
                mD[idx] = 1'b1;
            end
        end else begin
            expectCycle(1'b0, 32'd0, 1'b0, 1'b1, 6'd0, 64'd0, "dropped");
            step();
        end
        stalls = stallSeen;
        rd = sRdata;
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        logic [31:0] upper;
        logic [31:0] addr;
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic [63:0] line;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            line = {$urandom, $urandom};
            memArr[i] = line;
            refMem[i] = line;
        end
        memArr[2] = 64'hBBBBBBBB_AAAAAAAA;
        refMem[2] = 64'hBBBBBBBB_AAAAAAAA;
        clearModel();
        resetCycle();
        resetCycle();
        idleCycle();

        // Cold miss then neighbouring word hit
        access(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, st, rd);
        check("t1 stalls", st, 2);
        check("t1 rdata", {32'd0, rd}, 64'hAAAAAAAA);
        access(1'b0, 32'h14, 32'd0, 1'b0, 1'b0, st, rd);
        check("t1b stalls", st, 0);
        check("t1b rdata", {32'd0, rd}, 64'hBBBBBBBB);

        // Store hit, read back
        access(1'b1, 32'h14, 32'h12345678, 1'b0, 1'b0, st, rd);
        check("t2 store stalls", st, 0);
        access(1'b0, 32'h14, 32'd0, 1'b0, 1'b0, st, rd);
        check("t2 rdata", {32'd0, rd}, 64'h12345678);

        // Dirty conflict miss
        access(1'b0, 32'h50, 32'd0, 1'b0, 1'b0, st, rd);
        check("t3 stalls", st, 3);
        check("t3 written line", memArr[2], 64'h12345678_AAAAAAAA);

        // Reset during refill abandons the fill
        access(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, st, rd);
        check("t4 pre stalls", st, 2);
        access(1'b0, 32'h50, 32'd0, 1'b0, 1'b1, st, rd);
        check("t4 stalls before rst", st, 1);
        idleCycle();
        access(1'b0, 32'h50, 32'd0, 1'b0, 1'b0, st, rd);
        check("t4 re-miss stalls", st, 2);

        // High address bits alias
        access(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, st, rd);
        check("t5 fill stalls", st, 2);
        access(1'b0, 32'h210, 32'd0, 1'b0, 1'b0, st, rd);
        check("t5 alias stalls", st, 0);
        check("t5 alias rdata", {32'd0, rd}, 64'hAAAAAAAA);

        // Randomized traffic, biased toward a few tags to mix hits and conflicts
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                idleCycle();
            end else if ($urandom_range(0, 99) == 0) begin
                resetCycle();
            end else begin
                upper = $urandom;
                idx = 3'($urandom_range(0, 7));
                tg  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                  : 3'($urandom_range(0, 1));
                addr = {upper[31:9], tg, idx, upper[2:0]};
                access(1'($urandom_range(0, 1)), addr, $urandom,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, st, rd);
            end
        end
        idleCycle();
        chk = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
